// File: rtl/ssd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scanner
// Purpose  : Time-multiplexed driver for a 4-digit seven-segment display.
//            Each digit slot is a blanking interval followed by an on-time.
//            All four patterns are snapshotted once per frame so a digit never
//            shows a half-updated value.
// Ports    : clk_i          - board clock (single domain)
//            rst_ni         - asynchronous reset, active-low
//            disp0_i..3_i   - segment patterns, active-high, bit 7 = dp
//            blink_i        - per-digit blink request (bit i -> digit i)
//            seven_o        - cathodes, active-low
//            segment_o      - digit enables, active-low, one-hot-low when lit
//            frame_tick_o   - one-cycle pulse on the frame-start cycle
// Config   : define SSD_BLINK_EN to enable the blink feature; without it
//            blink_i is ignored and every digit displays normally.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scanner #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] disp0_i,
  input  logic [7:0] disp1_i,
  input  logic [7:0] disp2_i,
  input  logic [7:0] disp3_i,
  input  logic [3:0] blink_i,
  output logic [7:0] seven_o,
  output logic [3:0] segment_o,
  output logic       frame_tick_o
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       frame_q [4];
  logic             frame_start;
  logic             dark;

  // Frame start is decoded purely from state so it is also true during reset.
  assign frame_start = (state_q == ST_BLANK) && (digit_q == 2'd0) && (cnt_q == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_BLANK;
      digit_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame snapshot: taken only on the frame-start edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q[0] <= 8'h00;
      frame_q[1] <= 8'h00;
      frame_q[2] <= 8'h00;
      frame_q[3] <= 8'h00;
    end else if (frame_start) begin
      frame_q[0] <= disp0_i;
      frame_q[1] <= disp1_i;
      frame_q[2] <= disp2_i;
      frame_q[3] <= disp3_i;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt_q;
  logic            hidden_q;   // blink phase: 0 = visible, 1 = hidden
  logic [3:0]      mask_q;     // digits to darken for the current frame

  // The mask uses the phase held before this edge's toggle, so a frame shows
  // the phase that was in effect when its snapshot was taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q   <= '0;
      hidden_q <= 1'b0;
      mask_q   <= 4'h0;
    end else if (frame_start) begin
      mask_q <= blink_i & {4{hidden_q}};
      if (fcnt_q == FC_LAST) begin
        fcnt_q   <= '0;
        hidden_q <= ~hidden_q;
      end else begin
        fcnt_q <= fcnt_q + FC_W'(1);
      end
    end
  end

  assign dark = mask_q[digit_q];
`else
  localparam int BLINK_FRAMES_UNUSED = BLINK_FRAMES;
  logic blink_unused;
  assign blink_unused = ^blink_i;
  assign dark         = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output decode (outputs depend on registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q + CNT_W'(1);
    seven_o      = 8'hFF;
    segment_o    = 4'hF;
    frame_tick_o = frame_start;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (!dark) begin
          segment_o = ~(4'b0001 << digit_q);
          seven_o   = ~frame_q[digit_q];
        end
        if (cnt_q == DIGIT_LAST) begin
          state_d = ST_BLANK;
          digit_d = digit_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_BLANK;
        digit_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scanner
// Purpose  : Self-checking bench for ssd_scanner. A position-based model of
//            the frame pushes the expected outputs for every cycle into a
//            queue; they are popped and compared on the falling edge.
// Config   : honours SSD_BLINK_EN for the blink expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scanner;

  localparam int DIGIT = 4;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int SLOT  = DIGIT + BLANK;
  localparam int FRAME = 4 * SLOT;
`ifdef SSD_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] disp0, disp1, disp2, disp3;
  logic [3:0] blink;
  logic [7:0] seven;
  logic [3:0] segment;
  logic       frame_tick;

  ssd_scanner #(
    .DIGIT_CYCLES(DIGIT),
    .BLANK_CYCLES(BLANK),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .disp0_i     (disp0),
    .disp1_i     (disp1),
    .disp2_i     (disp2),
    .disp3_i     (disp3),
    .blink_i     (blink),
    .seven_o     (seven),
    .segment_o   (segment),
    .frame_tick_o(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;

  // Model state
  int          pos  = 0;   // position within the frame (0 = frame start)
  int          fnum = 0;   // frames started since reset release
  logic [7:0]  m_frame [4];
  logic [3:0]  m_blink  = 4'h0;
  bit          m_hidden = 1'b0;
  logic [12:0] exp_q [$];

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected {seven, segment, frame_tick} for the current model position.
  function automatic logic [12:0] model_out();
    int         slot = pos / SLOT;
    int         q    = pos % SLOT;
    logic [7:0] sv   = 8'hFF;
    logic [3:0] sg   = 4'hF;
    logic       tk   = (pos == 0);
    if (q >= BLANK) begin
      if (!(BLINK_ON && m_hidden && m_blink[slot])) begin
        sg = ~(4'b0001 << slot);
        sv = ~m_frame[slot];
      end
    end
    return {sv, sg, tk};
  endfunction

  // One clock: advance the model at the rising edge, push the expectation,
  // then pop and compare at the falling edge.
  task automatic tick_cycle();
    logic [12:0] e;
    @(posedge clk);
    if (!rst_n) begin
      pos  = 0;
      fnum = 0;
    end else begin
      if (pos == 0) begin
        m_frame[0] = disp0;
        m_frame[1] = disp1;
        m_frame[2] = disp2;
        m_frame[3] = disp3;
        m_blink    = blink;
        m_hidden   = ((fnum / BF) % 2) == 1;
        fnum++;
      end
      pos = (pos + 1) % FRAME;
    end
    exp_q.push_back(model_out());
    @(negedge clk);
    e = exp_q.pop_front();
    if (frame_tick === 1'b1) ticks++;
    chk($sformatf("f%0d_p%0d", fnum, pos), {seven, segment, frame_tick}, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    disp0 = 8'h01;
    disp1 = 8'h02;
    disp2 = 8'h04;
    disp3 = 8'h80;
    blink = 4'h0;

    // Reset held: blank outputs with frame_tick high.
    repeat (5) tick_cycle();

    // Scan order over two frames, one frame_tick per frame.
    rst_n = 1'b1;
    ticks = 0;
    repeat (2 * FRAME) tick_cycle();
    chk("tick_count", 13'(ticks), 13'd2);

    // Snapshot isolation: change disp3 while digit 1 is lit.
    repeat (SLOT + BLANK + 1) tick_cycle();
    disp3 = 8'hFF;
    repeat (FRAME - (SLOT + BLANK + 1)) tick_cycle();
    repeat (FRAME) tick_cycle();

    // Asynchronous reset during digit 2's on-time.
    repeat (2 * SLOT + BLANK) tick_cycle();
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {seven, segment, frame_tick}, {8'hFF, 4'hF, 1'b1});
    repeat (3) tick_cycle();
    rst_n = 1'b1;
    repeat (FRAME) tick_cycle();

    // Blink on digit 2 over six frames.
    rst_n = 1'b0;
    disp2 = 8'h3F;
    blink = 4'b0100;
    repeat (2) tick_cycle();
    rst_n = 1'b1;
    repeat (6 * FRAME) tick_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
